// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and event priority for the calculator core
package calc_pkg;

    typedef enum logic [2:0] {ENTRA_A, OP_WAIT, ENTRA_B, MOSTRA, ERRO} state_t;
    typedef enum logic {OP_ADD, OP_SUB} op_t;
    typedef enum logic [2:0] {EV_NENHUM, EV_RES, EV_ADD, EV_SUB, EV_TIRA, EV_BOTA, EV_DIG} evt_t;

    localparam int B_DIG  = 0;
    localparam int B_ADD  = 1;
    localparam int B_SUB  = 2;
    localparam int B_RES  = 3;
    localparam int B_BOTA = 4;
    localparam int B_TIRA = 5;

    // Only the highest-priority pulse of a cycle survives; the rest are dropped.
    function automatic evt_t prioriza(input logic [5:0] p);
        if (p[B_RES])       return EV_RES;
        else if (p[B_ADD])  return EV_ADD;
        else if (p[B_SUB])  return EV_SUB;
        else if (p[B_TIRA]) return EV_TIRA;
        else if (p[B_BOTA]) return EV_BOTA;
        else if (p[B_DIG])  return EV_DIG;
        else                return EV_NENHUM;
    endfunction

endpackage

// File: rtl/calc_nucleo_detecta_borda.sv
// rtl/calc_nucleo_detecta_borda.sv - registers level inputs and emits one-cycle rising-edge pulses
module detecta_borda #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] nivel,
    output logic [W-1:0] pulso
);

    logic [W-1:0] amostra_q, amostra_d;
    logic [W-1:0] anterior_q, anterior_d;

    always_comb begin
        amostra_d  = nivel;
        anterior_d = amostra_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amostra_q  <= '0;
            anterior_q <= '0;
        end else begin
            amostra_q  <= amostra_d;
            anterior_q <= anterior_d;
        end
    end

    assign pulso = amostra_q & ~anterior_q;

endmodule

// File: rtl/calc_nucleo.sv
// rtl/calc_nucleo.sv - chained add/sub calculator core; CALC_MEMORIA_EN enables the memory register
module calc_nucleo
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       numero,
    input  logic             digito_valido,
    input  logic             add,
    input  logic             sub,
    input  logic             resultado,
    input  logic             bota_memoria,
    input  logic             tira_memoria,
    output logic [VAL_W-1:0] valor,
    output logic             negativo,
    output logic             erro,
    output logic             mem_ativa,
    output logic             atualiza
);

    localparam int MAX = 10**DIGITS - 1;
    localparam int CW  = $clog2(DIGITS + 1);
    localparam logic signed [VAL_W-1:0] MAX_V = VAL_W'(MAX);
    localparam logic [CW-1:0]           DIG_C = CW'(DIGITS);

    logic [5:0] pulso, pulso_ef;
    evt_t       evento;

    detecta_borda #(.W(6)) u_borda (
        .clk   (clk),
        .rst   (rst),
        .nivel ({tira_memoria, bota_memoria, resultado, sub, add, digito_valido}),
        .pulso (pulso)
    );

    state_t                    state_q, state_d;
    op_t                       op_q, op_d, op_novo;
    logic signed [VAL_W-1:0]   acc_q, acc_d, entrada_q, entrada_d, valor_q, valor_d;
    logic signed [VAL_W-1:0]   soma;
    logic [CW-1:0]             contagem_q, contagem_d;
    logic [3:0]                numero_q, numero_d;
    logic                      erro_q, erro_d, negativo_q, negativo_d, atualiza_q, atualiza_d;
    logic                      ovf;
`ifdef CALC_MEMORIA_EN
    logic signed [VAL_W-1:0]   mem_q, mem_d;
    logic                      mem_ativa_q, mem_ativa_d;
`endif

    // Without the memory feature its key pulses are masked so they never steal priority.
    always_comb begin
`ifdef CALC_MEMORIA_EN
        pulso_ef = pulso;
`else
        pulso_ef = pulso & 6'b001111;
`endif
        evento = prioriza(pulso_ef);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        entrada_d  = entrada_q;
        contagem_d = contagem_q;
        erro_d     = erro_q;
        numero_d   = numero;
`ifdef CALC_MEMORIA_EN
        mem_d       = mem_q;
        mem_ativa_d = mem_ativa_q;
`endif
        soma    = (op_q == OP_ADD) ? acc_q + entrada_q : acc_q - entrada_q;
        ovf     = (soma > MAX_V) || (soma < -MAX_V);
        op_novo = (evento == EV_ADD) ? OP_ADD : OP_SUB;

        case (evento)
            EV_DIG: begin
                if (state_q == ENTRA_A || state_q == ENTRA_B) begin
                    if (contagem_q < DIG_C) begin
                        entrada_d  = (entrada_q <<< 3) + (entrada_q <<< 1) + {{(VAL_W-4){1'b0}}, numero_q};
                        contagem_d = contagem_q + CW'(1);
                    end
                end else begin
                    entrada_d  = {{(VAL_W-4){1'b0}}, numero_q};
                    contagem_d = CW'(1);
                    if (state_q == OP_WAIT) begin
                        state_d = ENTRA_B;
                    end else begin
                        acc_d   = '0;
                        erro_d  = 1'b0;
                        state_d = ENTRA_A;
                    end
                end
            end
            EV_ADD, EV_SUB: begin
                case (state_q)
                    ENTRA_A: begin
                        acc_d   = entrada_q;
                        op_d    = op_novo;
                        state_d = OP_WAIT;
                    end
                    ENTRA_B: begin
                        if (ovf) begin
                            erro_d  = 1'b1;
                            state_d = ERRO;
                        end else begin
                            acc_d   = soma;
                            op_d    = op_novo;
                            state_d = OP_WAIT;
                        end
                    end
                    OP_WAIT, MOSTRA: begin
                        op_d    = op_novo;
                        state_d = OP_WAIT;
                    end
                    default: ;
                endcase
            end
            EV_RES: begin
                case (state_q)
                    ENTRA_A: begin
                        acc_d   = entrada_q;
                        state_d = MOSTRA;
                    end
                    ENTRA_B: begin
                        if (ovf) begin
                            erro_d  = 1'b1;
                            state_d = ERRO;
                        end else begin
                            acc_d   = soma;
                            state_d = MOSTRA;
                        end
                    end
                    OP_WAIT: state_d = MOSTRA;
                    default: ;
                endcase
            end
`ifdef CALC_MEMORIA_EN
            EV_TIRA: begin
                if (state_q != ERRO && mem_ativa_q) begin
                    entrada_d  = mem_q;
                    contagem_d = DIG_C;
                    if (state_q == OP_WAIT)     state_d = ENTRA_B;
                    else if (state_q == MOSTRA) state_d = ENTRA_A;
                end
            end
            EV_BOTA: begin
                if (state_q != ERRO) begin
                    mem_d       = valor_q;
                    mem_ativa_d = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        case (state_d)
            ENTRA_A, ENTRA_B: valor_d = entrada_d;
            OP_WAIT, MOSTRA:  valor_d = acc_d;
            default:          valor_d = '0;
        endcase
        negativo_d = valor_d[VAL_W-1];
`ifdef CALC_MEMORIA_EN
        atualiza_d = (valor_d != valor_q) || (erro_d != erro_q) || (mem_ativa_d != mem_ativa_q);
`else
        atualiza_d = (valor_d != valor_q) || (erro_d != erro_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ENTRA_A;
            op_q       <= OP_ADD;
            acc_q      <= '0;
            entrada_q  <= '0;
            contagem_q <= '0;
            numero_q   <= '0;
            erro_q     <= 1'b0;
            valor_q    <= '0;
            negativo_q <= 1'b0;
            atualiza_q <= 1'b0;
`ifdef CALC_MEMORIA_EN
            mem_q       <= '0;
            mem_ativa_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            entrada_q  <= entrada_d;
            contagem_q <= contagem_d;
            numero_q   <= numero_d;
            erro_q     <= erro_d;
            valor_q    <= valor_d;
            negativo_q <= negativo_d;
            atualiza_q <= atualiza_d;
`ifdef CALC_MEMORIA_EN
            mem_q       <= mem_d;
            mem_ativa_q <= mem_ativa_d;
`endif
        end
    end

    assign valor    = valor_q;
    assign negativo = negativo_q;
    assign erro     = erro_q;
    assign atualiza = atualiza_q;
`ifdef CALC_MEMORIA_EN
    assign mem_ativa = mem_ativa_q;
`else
    assign mem_ativa = 1'b0;
`endif

endmodule

// File: tb/tb_calc_nucleo.sv
// tb/tb_calc_nucleo.sv - randomized and directed bench for calc_nucleo against a behavioural calculator model
module tb_calc_nucleo;

    localparam int MAXV = 9999;
    localparam int M_A = 0, M_W = 1, M_B = 2, M_S = 3, M_E = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  lv = '0;
    logic [3:0]  num_in = '0;
    logic [15:0] valor;
    logic        negativo, erro, mem_ativa, atualiza;

    int n_pass = 0;
    int n_total = 0;

    calc_nucleo dut (
        .clk           (clk),
        .rst           (rst),
        .numero        (num_in),
        .digito_valido (lv[0]),
        .add           (lv[1]),
        .sub           (lv[2]),
        .resultado     (lv[3]),
        .bota_memoria  (lv[4]),
        .tira_memoria  (lv[5]),
        .valor         (valor),
        .negativo      (negativo),
        .erro          (erro),
        .mem_ativa     (mem_ativa),
        .atualiza      (atualiza)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Calculator model: mode, accumulator, operand being typed, digit count, pending op.
    int m_mode = M_A, m_acc = 0, m_ent = 0, m_cnt = 0, m_op = 0, m_err = 0, m_mem = 0, m_mact = 0;
    int e_val = 0, e_err = 0, e_mact = 0, e_upd = 0;
    logic [5:0] s1 = '0, s2 = '0;
    int n1 = 0;

    function automatic int view(input int mode, input int acc, input int ent);
        if (mode == M_A || mode == M_B) return ent;
        if (mode == M_W || mode == M_S) return acc;
        return 0;
    endfunction

    task automatic m_arith(input bit fim, input int newop);
        int r;
        r = (m_op == 0) ? m_acc + m_ent : m_acc - m_ent;
        if (r > MAXV || r < -MAXV) begin
            m_err = 1; m_mode = M_E;
        end else begin
            m_acc = r;
            if (fim) m_mode = M_S;
            else begin m_op = newop; m_mode = M_W; end
        end
    endtask

    task automatic m_apply(input logic [5:0] ev_in, input int d);
        logic [5:0] ev;
        int pv;
        ev = ev_in;
`ifndef CALC_MEMORIA_EN
        ev[5:4] = 2'b00;
`endif
        if (ev[3]) begin
            if (m_mode == M_B) m_arith(1'b1, 0);
            else if (m_mode == M_A) begin m_acc = m_ent; m_mode = M_S; end
            else if (m_mode == M_W) m_mode = M_S;
        end else if (ev[1] || ev[2]) begin
            int o;
            o = ev[1] ? 0 : 1;
            if (m_mode == M_A) begin m_acc = m_ent; m_op = o; m_mode = M_W; end
            else if (m_mode == M_B) m_arith(1'b0, o);
            else if (m_mode == M_W || m_mode == M_S) begin m_op = o; m_mode = M_W; end
        end else if (ev[5]) begin
            if (m_mode != M_E && m_mact != 0) begin
                m_ent = m_mem; m_cnt = 4;
                if (m_mode == M_W) m_mode = M_B;
                else if (m_mode == M_S) m_mode = M_A;
            end
        end else if (ev[4]) begin
            if (m_mode != M_E) begin m_mem = e_val; m_mact = 1; end
        end else if (ev[0]) begin
            if (m_mode == M_A || m_mode == M_B) begin
                if (m_cnt < 4) begin m_ent = m_ent * 10 + d; m_cnt++; end
            end else if (m_mode == M_W) begin
                m_ent = d; m_cnt = 1; m_mode = M_B;
            end else begin
                m_ent = d; m_cnt = 1; m_acc = 0; m_err = 0; m_mode = M_A;
            end
        end
        pv = view(m_mode, m_acc, m_ent);
        e_upd = (pv != e_val || m_err != e_err || m_mact != e_mact) ? 1 : 0;
        e_val = pv; e_err = m_err; e_mact = m_mact;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_A; m_acc = 0; m_ent = 0; m_cnt = 0; m_op = 0; m_err = 0; m_mem = 0; m_mact = 0;
            e_val = 0; e_err = 0; e_mact = 0; e_upd = 0;
            s1 = '0; s2 = '0; n1 = 0;
        end else begin
            logic [5:0] ev;
            int d;
            ev = s1 & ~s2;
            d = n1;
            s2 = s1;
            s1 = lv;
            n1 = int'(num_in);
            m_apply(ev, d);
        end
    end

    always @(negedge clk) begin
        chk("valor", $signed(valor), e_val);
        chk("negativo", int'(negativo), (e_val < 0) ? 1 : 0);
        chk("erro", int'(erro), e_err);
        chk("mem_ativa", int'(mem_ativa), e_mact);
        chk("atualiza", int'(atualiza), e_upd);
    end

    task automatic press(input logic [5:0] m, input int n, input int hold, input int gap);
        lv = m;
        num_in = 4'(n);
        repeat (hold) @(negedge clk);
        lv = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic dig(input int n);
        press(6'b000001, n, 1, 3);
    endtask

    initial begin
        int mem_exp_val, mem_exp_act;
        repeat (3) @(negedge clk);
        chk("rst_valor", $signed(valor), 0);
        chk("rst_flags", int'({negativo, erro, mem_ativa, atualiza}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        dig(1);                           chk("s1_d1", $signed(valor), 1);
        dig(2);                           chk("s1_d2", $signed(valor), 12);
        press(6'b000010, 0, 1, 3);        chk("s1_add", $signed(valor), 12);
        dig(7);                           chk("s1_d7", $signed(valor), 7);
        press(6'b001000, 0, 1, 3);        chk("s1_res", $signed(valor), 19);

        dig(5);
        press(6'b000100, 0, 1, 3);
        dig(9);
        press(6'b001000, 0, 1, 3);        chk("s2_res", $signed(valor), -4);
                                          chk("s2_neg", int'(negativo), 1);
        dig(3);                           chk("s2_d3", $signed(valor), 3);
                                          chk("s2_pos", int'(negativo), 0);

        press(6'b001000, 0, 1, 3);
        repeat (4) dig(9);                chk("s3_9999", $signed(valor), 9999);
        press(6'b000010, 0, 1, 3);
        dig(1);
        press(6'b001000, 0, 1, 3);        chk("s3_ovf_erro", int'(erro), 1);
                                          chk("s3_ovf_val", $signed(valor), 0);
        dig(2);                           chk("s3_clr_erro", int'(erro), 0);
                                          chk("s3_clr_val", $signed(valor), 2);

        press(6'b001000, 0, 1, 3);
        for (int i = 1; i <= 5; i++) dig(i);
        chk("s4_cap", $signed(valor), 1234);
        press(6'b001000, 0, 1, 3);
        press(6'b000001, 7, 20, 3);       chk("s4_hold", $signed(valor), 7);

        press(6'b000011, 5, 1, 3);        chk("s5_prio", $signed(valor), 7);
        dig(3);                           chk("s5_b", $signed(valor), 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("s5_arst_val", $signed(valor), 0);
        chk("s5_arst_flags", int'({negativo, erro, mem_ativa, atualiza}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        dig(4);
        dig(2);
        press(6'b010000, 0, 1, 3);
        press(6'b000010, 0, 1, 3);
        press(6'b100000, 0, 1, 3);
        press(6'b001000, 0, 1, 3);
`ifdef CALC_MEMORIA_EN
        mem_exp_val = 84; mem_exp_act = 1;
`else
        mem_exp_val = 42; mem_exp_act = 0;
`endif
        chk("s6_mem_val", $signed(valor), mem_exp_val);
        chk("s6_mem_act", int'(mem_ativa), mem_exp_act);

        for (int k = 0; k < 400; k++) begin
            int r;
            logic [5:0] m;
            r = $urandom_range(0, 99);
            if (r < 55)      m = 6'b000001;
            else if (r < 65) m = 6'b000010;
            else if (r < 72) m = 6'b000100;
            else if (r < 82) m = 6'b001000;
            else if (r < 87) m = 6'b010000;
            else if (r < 92) m = 6'b100000;
            else             m = 6'($urandom_range(1, 63));
            press(m, $urandom_range(0, 9), $urandom_range(1, 3), $urandom_range(0, 2));
        end
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
